// File: rtl/cpu_memory_stage.sv
// cpu_memory_stage: stack CPU stage 3a->4a.
// Resolves branches, selects the stack push word and registers the 3a->4a
// pipeline slot. Loads and stores go through a variable-latency req/ack bus
// master, and upstream is stalled until the access completes.
// Optional feature macro: CPU_MEM_TIMEOUT_EN adds a bus timeout counter and
// the o_bus_err pulse output; without it a request waits for ack forever.
module cpu_memory_stage #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3,
  parameter int ADDR_W = 8,
  parameter int PC_W   = 32,
  parameter int OFFS_W = 16,
  parameter int POP_W  = 11
`ifdef CPU_MEM_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_in_valid_3a,
  input  logic [1:0]              i_c__branch_3a,
  input  logic                    i_alu__cond_3a,
  input  logic [DATA_W-1:0]       i_alu__out_3a,
  input  logic [OFFS_W-1:0]       i_offs_3a,
  input  logic [PC_W-1:0]         i_pc_3a,
  input  logic                    i_c__mem_rd_3a,
  input  logic                    i_c__mem_write_3a,
  input  logic [ADDR_W-1:0]       i_c__mem_addr_3a,
  input  logic [2:0]              i_c__to_push_3a,
  input  logic [TAG_W+DATA_W-1:0] i_imm_3a,
  input  logic [TAG_W+DATA_W-1:0] i_r0_3a,
  input  logic [TAG_W+DATA_W-1:0] i_r1_3a,
  input  logic [POP_W-1:0]        i_st__to_pop_3a,
  input  logic                    i_stall_4a,
  output logic                    o_stall_3a,
  output logic                    o_kill_4a,
  output logic [PC_W-1:0]         o_branch_target_4a,
  output logic                    o_valid_4a,
  output logic [PC_W-1:0]         o_pc_4a,
  output logic [2:0]              o_c__to_push_4a,
  output logic [POP_W-1:0]        o_st__to_pop_4a,
  output logic [TAG_W+DATA_W-1:0] o_st__to_push_4a,
  output logic                    o_bus_req,
  output logic                    o_bus_we,
  output logic [ADDR_W-1:0]       o_bus_addr,
  output logic [DATA_W-1:0]       o_bus_wdata,
`ifdef CPU_MEM_TIMEOUT_EN
  output logic                    o_bus_err,
`endif
  input  logic                    i_bus_ack,
  input  logic [DATA_W-1:0]       i_bus_rdata
);

  localparam logic [1:0] BR_NONE     = 2'd0;
  localparam logic [1:0] BR_REL      = 2'd1;
  localparam logic [1:0] BR_REL_COND = 2'd2;
  localparam logic [1:0] BR_ALU      = 2'd3;

  localparam logic [2:0] PUSH_NONE = 3'd0;
  localparam logic [2:0] PUSH_ALU  = 3'd1;
  localparam logic [2:0] PUSH_IMM  = 3'd2;
  localparam logic [2:0] PUSH_REG0 = 3'd3;
  localparam logic [2:0] PUSH_REG1 = 3'd4;
  localparam logic [2:0] PUSH_MEM  = 3'd5;

  localparam logic [TAG_W-1:0] TYPE_INTEGER = TAG_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                    r_state;
  logic                      r_busWe;
  logic [ADDR_W-1:0]         r_busAddr;
  logic [DATA_W-1:0]         r_busWdata;
  logic [DATA_W-1:0]         r_rdata;
  logic                      r_valid4a;
  logic [PC_W-1:0]           r_pc4a;
  logic [2:0]                r_toPush4a;
  logic [POP_W-1:0]          r_toPop4a;
  logic [TAG_W+DATA_W-1:0]   r_pushWord4a;

  logic                      w_isMem;
  logic                      w_stall3a;
  logic                      w_adv;
  logic                      w_taken;
  logic [PC_W-1:0]           w_target;
  logic [POP_W-1:0]          w_popCount;
  logic [TAG_W+DATA_W-1:0]   w_pushWord;

`ifdef CPU_MEM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  logic [TMR_W-1:0]          r_timer;
  logic                      r_busErr;
  assign o_bus_err = r_busErr;
`endif

  assign w_isMem = i_in_valid_3a & (i_c__mem_rd_3a | i_c__mem_write_3a);
  assign w_adv   = i_in_valid_3a & ~w_stall3a;

  // Upstream holds while an access is being started or is on the bus
  always_comb begin
    w_stall3a = 1'b1;
    case (r_state)
      S_IDLE:  w_stall3a = w_isMem | i_stall_4a;
      S_REQ:   w_stall3a = 1'b1;
      S_DONE:  w_stall3a = i_stall_4a;
      default: w_stall3a = 1'b1;
    endcase
  end

  // Branch decision: unconditional kinds always redirect, REL_COND on the ALU flag
  always_comb begin
    w_taken = 1'b0;
    case (i_c__branch_3a)
      BR_NONE:     w_taken = 1'b0;
      BR_REL:      w_taken = 1'b1;
      BR_REL_COND: w_taken = i_alu__cond_3a;
      BR_ALU:      w_taken = 1'b1;
      default:     w_taken = 1'b0;
    endcase
  end

  assign w_target = (i_c__branch_3a == BR_ALU) ? PC_W'(i_alu__out_3a)
                                               : i_pc_3a + PC_W'($signed(i_offs_3a));

  assign w_popCount = (i_st__to_pop_3a == POP_W'(3)) ? i_alu__out_3a[POP_W-1:0]
                                                     : i_st__to_pop_3a;

  // Push word selection; loaded data is tagged as an integer like ALU results
  always_comb begin
    w_pushWord = '0;
    case (i_c__to_push_3a)
      PUSH_NONE: w_pushWord = '0;
      PUSH_ALU:  w_pushWord = {TYPE_INTEGER, i_alu__out_3a};
      PUSH_IMM:  w_pushWord = i_imm_3a;
      PUSH_REG0: w_pushWord = i_r0_3a;
      PUSH_REG1: w_pushWord = i_r1_3a;
      PUSH_MEM:  w_pushWord = {TYPE_INTEGER, r_rdata};
      default:   w_pushWord = '0;
    endcase
  end

  // Bus master FSM: one outstanding access, store wins when rd and wr are both set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busWe    <= 1'b0;
      r_busAddr  <= '0;
      r_busWdata <= '0;
      r_rdata    <= '0;
`ifdef CPU_MEM_TIMEOUT_EN
      r_timer    <= '0;
      r_busErr   <= 1'b0;
`endif
    end else begin
`ifdef CPU_MEM_TIMEOUT_EN
      r_busErr <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_isMem) begin
            r_busWe    <= i_c__mem_write_3a;
            r_busAddr  <= i_c__mem_addr_3a;
            r_busWdata <= i_alu__out_3a;
            r_state    <= S_REQ;
`ifdef CPU_MEM_TIMEOUT_EN
            r_timer    <= '0;
`endif
          end
        end
        S_REQ: begin
          if (i_bus_ack) begin
            r_rdata <= i_bus_rdata;
            r_state <= S_DONE;
          end
`ifdef CPU_MEM_TIMEOUT_EN
          else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
            r_rdata  <= '0;
            r_busErr <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
`endif
        end
        S_DONE: begin
          if (!i_stall_4a) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // 4a pipeline slot: load on advance, bubble when downstream drains, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid4a    <= 1'b0;
      r_pc4a       <= '0;
      r_toPush4a   <= '0;
      r_toPop4a    <= '0;
      r_pushWord4a <= '0;
    end else if (w_adv) begin
      r_valid4a    <= 1'b1;
      r_pc4a       <= i_pc_3a;
      r_toPush4a   <= i_c__to_push_3a;
      r_toPop4a    <= w_popCount;
      r_pushWord4a <= w_pushWord;
    end else if (!i_stall_4a) begin
      r_valid4a    <= 1'b0;
    end
  end

  assign o_stall_3a         = w_stall3a;
  assign o_kill_4a          = w_adv & w_taken;
  assign o_branch_target_4a = w_target;
  assign o_valid_4a         = r_valid4a;
  assign o_pc_4a            = r_pc4a;
  assign o_c__to_push_4a    = r_toPush4a;
  assign o_st__to_pop_4a    = r_toPop4a;
  assign o_st__to_push_4a   = r_pushWord4a;
  assign o_bus_req          = (r_state == S_REQ);
  assign o_bus_we           = r_busWe;
  assign o_bus_addr         = r_busAddr;
  assign o_bus_wdata        = r_busWdata;

endmodule
